// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline: datapath width, load-type
// encodings and the hard-wired zero register.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Encodings 5-7 are unused and treated as LW by the aligner.
  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } load_type_e;

endpackage

// File: rtl/load_align.sv
// Combinational little-endian load aligner: picks the addressed byte or
// halfword out of the raw memory word and sign- or zero-extends it.
module load_align
  import mips_pkg::*;
(
  input  logic [2:0]      load_type,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{byte_off, 3'b000} +: 8];
  assign half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    // NOTE: data gets a default before the case so every path assigns it
    // and no latch is inferred.
    data = rdata;
    case (load_type_e'(load_type))
      LD_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      LD_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment ahead of the flops.
// Optional retired-instruction counter enabled by `define MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            in_reg_write,
  input  logic            in_mem_to_reg,
  input  logic [2:0]      in_load_type,
  input  logic [1:0]      in_byte_off,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [4:0]      in_rd,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_reg_write_en,
  output logic            wb_valid
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [31:0]     retire_cnt
`endif
);

  logic [XLEN-1:0] load_data;

  logic            valid_q, valid_d;
  logic            we_q,    we_d;
  logic [4:0]      rd_q,    rd_d;
  logic [XLEN-1:0] data_q,  data_d;

  load_align u_load_align (
    .load_type (in_load_type),
    .byte_off  (in_byte_off),
    .rdata     (in_mem_rdata),
    .data      (load_data)
  );

  // The write enable is resolved before the flop so every wb_* output is a
  // plain register; a capture with in_valid=0 can never enable a write.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      rd_d    = '0;
      data_d  = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      we_d    = in_valid && in_reg_write && (in_rd != mips_pkg::REG_ZERO);
      rd_d    = in_rd;
      data_d  = in_mem_to_reg ? load_data : in_alu_result;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign wb_valid        = valid_q;
  assign wb_reg_write_en = we_q;
  assign wb_rd           = rd_q;
  assign wb_data         = data_q;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!flush && !stall && in_valid) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign retire_cnt = cnt_q;
`endif

endmodule
